adc_phase_current: RTL and testbench
====================================

# adc_phase_current

Downstream consumer of the AD7928 SPI sampler. Takes the three raw 12-bit phase-current ADC words from each conversion-done pulse, calibrates the per-channel zero-current offset from the first samples after reset or recalibration, and then emits offset-corrected, saturated, signed phase currents. These currents feed the Clarke/Park transform stage of the FOC loop.

## Interface

Parameters:
- CAL_SKIP, default 8'd4: number of valid samples discarded after reset or recalibration, to let the ADC and analog front end settle.
- CAL_SHIFT, default 4'd6: log2 of the number of samples averaged for the offset; 2^CAL_SHIFT samples; legal range 1..8.
- OFS_TOL, default 12'd400: maximum allowed |offset − 2048| per channel; a larger deviation is a calibration failure.

Ports:
- clk, input, 1: clock.
- rstn, input, 1: reset, asynchronous, active-low.
- i_recal, input, 1: one-cycle pulse; restarts calibration.
- i_en_adc, input, 1: one-cycle pulse; the three ADC words are valid this cycle.
- i_adc_a, input, 12: raw unsigned ADC word, phase A.
- i_adc_b, input, 12: raw unsigned ADC word, phase B.
- i_adc_c, input, 12: raw unsigned ADC word, phase C.
- o_en_iabc, input-aligned output, 1: one-cycle pulse; o_ia/o_ib/o_ic are updated this cycle.
- o_ia, output, 12 signed: phase A current.
- o_ib, output, 12 signed: phase B current.
- o_ic, output, 12 signed: phase C current.
- o_calib_done, output, 1: high while in RUN.
- o_calib_err, output, 1: high while in FAIL.

## Operation

- States: SKIP, ACCUM, CHECK, RUN, FAIL. Reset enters SKIP.
- **SKIP:** skip counter increments on each i_en_adc; the sample is discarded. The sample that brings the count to CAL_SKIP moves the FSM to ACCUM. With CAL_SKIP=0, SKIP exits on the first clock and consumes no sample.
- **ACCUM:** on each i_en_adc, acc_x += i_adc_x.
  - Accumulators are 12+CAL_SHIFT bits unsigned, cleared on entry to ACCUM; they never overflow.
  - The 2^CAL_SHIFT-th sample moves the FSM to CHECK.
- **CHECK** (exactly 1 cycle):
  - ofs_x <= acc_x >> CAL_SHIFT (truncating).
  - If any |acc_x>>CAL_SHIFT − 2048| > OFS_TOL, next state is FAIL; otherwise RUN.
  - i_en_adc arriving during CHECK is ignored.
- **RUN:** on i_en_adc:
  - d_x = {1'b0,i_adc_x} − {1'b0,ofs_x}, 13-bit signed, range −4095..4095.
  - o_x <= sat12(d_x): values above 2047 become 2047; values below −2048 become −2048.
  - o_en_iabc pulses the next cycle.
- **FAIL:** no o_en_iabc pulses; outputs hold. The FSM leaves only on i_recal or reset.
- **i_recal**, in any state:
  - Next state is SKIP; counters and accumulators clear; o_calib_done and o_calib_err drop the next cycle.
  - ofs_x and o_ia/o_ib/o_ic hold their values.
  - i_recal has priority over a simultaneous i_en_adc; that sample is discarded and produces no o_en_iabc.
- o_en_iabc is never asserted outside RUN.

## Timing

- Reset values: o_en_iabc=0, o_ia=o_ib=o_ic=0, o_calib_done=0, o_calib_err=0, ofs_x=0, all counters and accumulators 0, state SKIP.
- RUN latency: i_en_adc in cycle T gives o_en_iabc=1 and new currents in cycle T+1. Currents hold until the next pulse.
- Calibration: the last ACCUM sample in cycle T gives CHECK in T+1. In T+2 the FSM is in RUN with o_calib_done=1, or in FAIL with o_calib_err=1.
- A RUN sample at T+2 or later is converted using the new offsets.
- Back-to-back i_en_adc on consecutive cycles must be handled in every state; no sample is dropped in SKIP, ACCUM or RUN.
- Reset deassertion mid-calibration restarts from SKIP with no residue.

## Test plan

- **Nominal calibration:** CAL_SKIP=4, CAL_SHIFT=6. Drive 4 samples of 0/0/0, then 64 samples of 2048/2000/2100. Expect no o_en_iabc, and o_calib_done=1 exactly 2 cycles after the 68th pulse. Then drive 2148/1900/2100; the next cycle expects o_en_iabc=1 with ia=100, ib=−100, ic=0.
- **Truncation:** during ACCUM, A alternates 2048/2049 (sum 131104). Expect ofs_a=2048. A RUN sample of 2049 gives ia=1.
- **Saturation:** offsets 2048/2048/2048. Samples 0/4095/2048 give ia=−2048, ib=2047, ic=0. With offset 1648 (within tolerance), sample 4095 gives ia=2047 (d=2447, clipped).
- **Calibration failure:** channel C calibrated at constant 2449 (dev 401). Expect o_calib_err=1, o_calib_done=0, and no o_en_iabc for 10 subsequent pulses. i_recal then clears o_calib_err and restarts SKIP.
- **Recal priority:** in RUN, assert i_recal in the same cycle as i_en_adc. Expect no o_en_iabc; o_calib_done=0 the next cycle; outputs hold their previous values; recalibration completes after 4+64 further pulses.
- **Async reset mid-ACCUM:** after 30 accumulated samples, pulse rstn low. Expect all outputs 0 immediately. A full fresh calibration then yields the offset of the new samples only.

Source files
------------

// File: rtl/adc_phase_current.sv
// Phase-current front end: calibrates per-channel ADC zero offsets after reset/recal,
// then emits offset-corrected, saturated signed currents for the FOC transform stage.
module adc_phase_current #(
   parameter logic [7:0]  CAL_SKIP  = 8'd4,
   parameter logic [3:0]  CAL_SHIFT = 4'd6,
   parameter logic [11:0] OFS_TOL   = 12'd400
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               i_recal,
   input  logic               i_en_adc,
   input  logic [11:0]        i_adc_a,
   input  logic [11:0]        i_adc_b,
   input  logic [11:0]        i_adc_c,
   output logic               o_en_iabc,
   output logic signed [11:0] o_ia,
   output logic signed [11:0] o_ib,
   output logic signed [11:0] o_ic,
   output logic               o_calib_done,
   output logic               o_calib_err
);

   localparam int unsigned ACC_W    = 32'd12 + 32'(CAL_SHIFT);
   localparam logic [8:0]  LAST_SMP = 9'((32'd1 << CAL_SHIFT) - 32'd1);

   typedef enum logic [2:0] {S_SKIP, S_ACCUM, S_CHECK, S_RUN, S_FAIL} state_t;

   state_t             r_state, w_next;
   logic [7:0]         r_skip_cnt;
   logic [8:0]         r_smp_cnt;
   logic [ACC_W-1:0]   r_acc_a, r_acc_b, r_acc_c;
   logic [11:0]        r_ofs_a, r_ofs_b, r_ofs_c;
   logic               r_en_iabc, r_calib_done, r_calib_err;
   logic [11:0]        r_ia, r_ib, r_ic;
   logic [11:0]        w_mean_a, w_mean_b, w_mean_c;
   logic               w_cal_bad;
   logic               w_skip_inc, w_skip_clr, w_acc_en, w_acc_clr, w_ofs_ld, w_conv;
   logic               w_done_nx, w_err_nx;
   logic [12:0]        w_d_a, w_d_b, w_d_c;

   // |mean - 2048| beyond tolerance
   function automatic logic dev_bad(input logic [11:0] m);
      logic [12:0] d;
      d = (m >= 12'd2048) ? (13'(m) - 13'd2048) : (13'd2048 - 13'(m));
      return d > 13'(OFS_TOL);
   endfunction

   // Clip 13-bit signed difference into 12-bit signed range
   function automatic logic [11:0] sat12(input logic [12:0] d);
      if (d[12] != d[11]) return d[12] ? 12'h800 : 12'h7FF;
      return d[11:0];
   endfunction

   assign w_mean_a  = 12'(r_acc_a >> CAL_SHIFT);
   assign w_mean_b  = 12'(r_acc_b >> CAL_SHIFT);
   assign w_mean_c  = 12'(r_acc_c >> CAL_SHIFT);
   assign w_cal_bad = dev_bad(w_mean_a) | dev_bad(w_mean_b) | dev_bad(w_mean_c);

   assign w_d_a = 13'({1'b0, i_adc_a}) - 13'({1'b0, r_ofs_a});
   assign w_d_b = 13'({1'b0, i_adc_b}) - 13'({1'b0, r_ofs_b});
   assign w_d_c = 13'({1'b0, i_adc_c}) - 13'({1'b0, r_ofs_c});

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_SKIP;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (i_recal) begin
         w_next = S_SKIP;
      end else begin
         case (r_state)
            S_SKIP:  if ((CAL_SKIP == 8'd0) ||
                         (i_en_adc && (r_skip_cnt == CAL_SKIP - 8'd1))) w_next = S_ACCUM;
            S_ACCUM: if (i_en_adc && (r_smp_cnt == LAST_SMP))           w_next = S_CHECK;
            S_CHECK: w_next = w_cal_bad ? S_FAIL : S_RUN;
            S_RUN:   w_next = S_RUN;
            S_FAIL:  w_next = S_FAIL;
            default: w_next = S_SKIP;
         endcase
      end
   end

   // Datapath controls; recal suppresses every update except the clears
   always_comb begin
      w_skip_inc = 1'b0;
      w_skip_clr = 1'b0;
      w_acc_en   = 1'b0;
      w_acc_clr  = 1'b0;
      w_ofs_ld   = 1'b0;
      w_conv     = 1'b0;
      w_done_nx  = (w_next == S_RUN);
      w_err_nx   = (w_next == S_FAIL);
      if (i_recal) begin
         w_skip_clr = 1'b1;
         w_acc_clr  = 1'b1;
      end else begin
         w_skip_inc = (r_state == S_SKIP)  && i_en_adc;
         w_skip_clr = (r_state != S_SKIP);
         w_acc_clr  = (r_state == S_SKIP);
         w_acc_en   = (r_state == S_ACCUM) && i_en_adc;
         w_ofs_ld   = (r_state == S_CHECK);
         w_conv     = (r_state == S_RUN)   && i_en_adc;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_skip_cnt   <= '0;
         r_smp_cnt    <= '0;
         r_acc_a      <= '0;
         r_acc_b      <= '0;
         r_acc_c      <= '0;
         r_ofs_a      <= '0;
         r_ofs_b      <= '0;
         r_ofs_c      <= '0;
         r_en_iabc    <= 1'b0;
         r_ia         <= '0;
         r_ib         <= '0;
         r_ic         <= '0;
         r_calib_done <= 1'b0;
         r_calib_err  <= 1'b0;
      end else begin
         if (w_skip_clr)      r_skip_cnt <= '0;
         else if (w_skip_inc) r_skip_cnt <= r_skip_cnt + 8'd1;
         if (w_acc_clr) begin
            r_smp_cnt <= '0;
            r_acc_a   <= '0;
            r_acc_b   <= '0;
            r_acc_c   <= '0;
         end else if (w_acc_en) begin
            r_smp_cnt <= r_smp_cnt + 9'd1;
            r_acc_a   <= r_acc_a + ACC_W'(i_adc_a);
            r_acc_b   <= r_acc_b + ACC_W'(i_adc_b);
            r_acc_c   <= r_acc_c + ACC_W'(i_adc_c);
         end
         if (w_ofs_ld) begin
            r_ofs_a <= w_mean_a;
            r_ofs_b <= w_mean_b;
            r_ofs_c <= w_mean_c;
         end
         r_en_iabc <= w_conv;
         if (w_conv) begin
            r_ia <= sat12(w_d_a);
            r_ib <= sat12(w_d_b);
            r_ic <= sat12(w_d_c);
         end
         r_calib_done <= w_done_nx;
         r_calib_err  <= w_err_nx;
      end
   end

   assign o_en_iabc    = r_en_iabc;
   assign o_ia         = r_ia;
   assign o_ib         = r_ib;
   assign o_ic         = r_ic;
   assign o_calib_done = r_calib_done;
   assign o_calib_err  = r_calib_err;

endmodule

// File: tb/tb_adc_phase_current.sv
// Randomized bench for adc_phase_current against a sample-queue calibration model.
module tb_adc_phase_current;

   localparam int N_SKIP = 4;
   localparam int N_AVG  = 64;
   localparam int TOL    = 400;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        i_recal = 1'b0;
   logic        i_en_adc = 1'b0;
   logic [11:0] i_adc_a = '0, i_adc_b = '0, i_adc_c = '0;
   logic        o_en_iabc, o_calib_done, o_calib_err;
   logic signed [11:0] o_ia, o_ib, o_ic;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: samples counted since (re)start, calibration sample queues, offsets and outputs
   int m_skipped;
   int q_a[$], q_b[$], q_c[$];
   bit m_check, m_done, m_err, m_en;
   int m_ofs[3];
   int m_out[3];

   adc_phase_current dut (
      .clk(clk), .rstn(rstn), .i_recal(i_recal), .i_en_adc(i_en_adc),
      .i_adc_a(i_adc_a), .i_adc_b(i_adc_b), .i_adc_c(i_adc_c),
      .o_en_iabc(o_en_iabc), .o_ia(o_ia), .o_ib(o_ib), .o_ic(o_ic),
      .o_calib_done(o_calib_done), .o_calib_err(o_calib_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int sat(input int d);
      return (d > 2047) ? 2047 : ((d < -2048) ? -2048 : d);
   endfunction

   function automatic int mean_of(input int q[$]);
      int s = 0;
      foreach (q[i]) s += q[i];
      return s / N_AVG;
   endfunction

   function automatic int absi(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic model_reset();
      m_skipped = 0;
      q_a.delete(); q_b.delete(); q_c.delete();
      m_check = 0; m_done = 0; m_err = 0; m_en = 0;
      m_ofs = '{0, 0, 0};
      m_out = '{0, 0, 0};
   endtask

   task automatic model_step(input bit recal, input bit en, input int a, input int b, input int c);
      m_en = 0;
      if (recal) begin
         m_skipped = 0;
         q_a.delete(); q_b.delete(); q_c.delete();
         m_check = 0; m_done = 0; m_err = 0;
      end else if (m_check) begin
         m_ofs[0] = mean_of(q_a);
         m_ofs[1] = mean_of(q_b);
         m_ofs[2] = mean_of(q_c);
         m_err = (absi(m_ofs[0] - 2048) > TOL) || (absi(m_ofs[1] - 2048) > TOL) ||
                 (absi(m_ofs[2] - 2048) > TOL);
         m_done = !m_err;
         m_check = 0;
      end else if (m_done) begin
         if (en) begin
            m_out[0] = sat(a - m_ofs[0]);
            m_out[1] = sat(b - m_ofs[1]);
            m_out[2] = sat(c - m_ofs[2]);
            m_en = 1;
         end
      end else if (!m_err && en) begin
         if (m_skipped < N_SKIP) m_skipped++;
         else begin
            q_a.push_back(a); q_b.push_back(b); q_c.push_back(c);
            if (q_a.size() == N_AVG) m_check = 1;
         end
      end
   endtask

   task automatic cmp_all(input string ph);
      chk({ph, ".en_iabc"}, int'(o_en_iabc), int'(m_en));
      chk({ph, ".ia"}, int'(o_ia), m_out[0]);
      chk({ph, ".ib"}, int'(o_ib), m_out[1]);
      chk({ph, ".ic"}, int'(o_ic), m_out[2]);
      chk({ph, ".done"}, int'(o_calib_done), int'(m_done));
      chk({ph, ".err"}, int'(o_calib_err), int'(m_err));
   endtask

   // One clock: drive, let the edge happen, update model, sample #1 later
   task automatic step(input bit recal, input bit en, input int a, input int b, input int c);
      i_recal  = recal;
      i_en_adc = en;
      i_adc_a  = 12'(a);
      i_adc_b  = 12'(b);
      i_adc_c  = 12'(c);
      @(posedge clk);
      model_step(recal, en, a, b, c);
      #1;
      cmp_all("cyc");
      i_recal  = 1'b0;
      i_en_adc = 1'b0;
   endtask

   task automatic calibrate(input int a, input int b, input int c);
      for (int i = 0; i < N_SKIP; i++) step(0, 1, 0, 0, 0);
      for (int i = 0; i < N_AVG; i++) step(0, 1, a, b, c);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
   endtask

   function automatic int clip12u(input int v);
      return (v < 0) ? 0 : ((v > 4095) ? 4095 : v);
   endfunction

   initial begin
      model_reset();
      #12;
      cmp_all("reset");
      @(negedge clk);
      rstn = 1'b1;

      // Nominal calibration and first conversion
      calibrate(2048, 2000, 2100);
      chk("nominal.done", int'(o_calib_done), 1);
      step(0, 1, 2148, 1900, 2100);
      chk("nominal.ia", int'(o_ia), 100);
      chk("nominal.ib", int'(o_ib), -100);
      chk("nominal.ic", int'(o_ic), 0);
      step(1, 1, 9, 9, 9);
      chk("recal_prio.en", int'(o_en_iabc), 0);
      chk("recal_prio.hold", int'(o_ib), -100);

      // Truncating average: A alternates 2048/2049
      for (int i = 0; i < N_SKIP; i++) step(0, 1, 4095, 0, 17);
      for (int i = 0; i < N_AVG; i++) step(0, 1, 2048 + (i % 2), 2048, 2048);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 2049, 2048, 2048);
      chk("trunc.ia", int'(o_ia), 1);

      // Saturation at both rails
      step(1, 0, 0, 0, 0);
      calibrate(2048, 2048, 2048);
      step(0, 1, 0, 4095, 2048);
      chk("sat.ia", int'(o_ia), -2048);
      chk("sat.ib", int'(o_ib), 2047);
      step(1, 0, 0, 0, 0);
      calibrate(1648, 2048, 2048);
      chk("tol_edge.done", int'(o_calib_done), 1);
      step(0, 1, 4095, 2048, 2048);
      chk("sat_clip.ia", int'(o_ia), 2047);

      // Calibration failure on channel C, then recovery
      step(1, 0, 0, 0, 0);
      calibrate(2048, 2048, 2449);
      chk("fail.err", int'(o_calib_err), 1);
      for (int i = 0; i < 10; i++) step(0, 1, 3000, 1000, 2000);
      step(1, 0, 0, 0, 0);
      chk("fail.recal_clr", int'(o_calib_err), 0);
      calibrate(2100, 2000, 1900);

      // Async reset mid-ACCUM
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < N_SKIP; i++) step(0, 1, 0, 0, 0);
      for (int i = 0; i < 30; i++) step(0, 1, 1700, 2400, 1800);
      #2;
      rstn = 1'b0;
      #1;
      model_reset();
      cmp_all("async_rst");
      @(negedge clk);
      rstn = 1'b1;
      calibrate(2200, 2300, 1900);
      step(0, 1, 2200, 2300, 1900);
      chk("post_rst.ia", int'(o_ia), 0);

      // Random traffic with gaps, back-to-back pulses and occasional recal
      for (int r = 0; r < 6; r++) begin
         int ba, bb, bc;
         ba = 2048 + int'($urandom_range(0, 900)) - 450;
         bb = 2048 + int'($urandom_range(0, 900)) - 450;
         bc = 2048 + int'($urandom_range(0, 900)) - 450;
         step(1, ($urandom % 2) == 0, ba, bb, bc);
         for (int i = 0; i < 400; i++) begin
            bit en, rc;
            en = ($urandom % 4) != 0;
            rc = ($urandom % 300) == 0;
            if (m_done)
               step(rc, en, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                    int'($urandom_range(0, 4095)));
            else
               step(rc, en, clip12u(ba + int'($urandom_range(0, 40)) - 20),
                    clip12u(bb + int'($urandom_range(0, 40)) - 20),
                    clip12u(bc + int'($urandom_range(0, 40)) - 20));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
